// File: rtl/add_stream_ctrl.sv
// Stream front end for an external 33-bit-result prefix adder, with an optional accumulator.
// Optional build macro ADD_STREAM_SAT_EN: accumulate-mode carry-out saturates to all ones.
//   state | meaning
//   IDLE  | ready for a request
//   CALC  | adder operands registered, capture result
//   HOLD  | result presented until consumer takes it
module add_stream_ctrl #(
  parameter logic [31:0] ACC_INIT = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        in_cin,
  input  logic        in_acc,
  input  logic        in_clr,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  output logic        add_cin,
  input  logic [32:0] add_sum,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_sum,
  output logic        out_cout,
  output logic [31:0] acc_val
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] add_a_q, add_a_d;
  logic [31:0] add_b_q, add_b_d;
  logic        add_cin_q, add_cin_d;
  logic        acc_mode_q, acc_mode_d;
  logic [31:0] out_sum_q, out_sum_d;
  logic        out_cout_q, out_cout_d;
  logic [31:0] acc_q, acc_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      add_a_q    <= '0;
      add_b_q    <= '0;
      add_cin_q  <= 1'b0;
      acc_mode_q <= 1'b0;
      out_sum_q  <= '0;
      out_cout_q <= 1'b0;
      acc_q      <= ACC_INIT;
    end else begin
      state_q    <= state_d;
      add_a_q    <= add_a_d;
      add_b_q    <= add_b_d;
      add_cin_q  <= add_cin_d;
      acc_mode_q <= acc_mode_d;
      out_sum_q  <= out_sum_d;
      out_cout_q <= out_cout_d;
      acc_q      <= acc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    add_a_d    = add_a_q;
    add_b_d    = add_b_q;
    add_cin_d  = add_cin_q;
    acc_mode_d = acc_mode_q;
    out_sum_d  = out_sum_q;
    out_cout_d = out_cout_q;
    acc_d      = acc_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          add_a_d    = in_a;
          add_cin_d  = in_cin;
          acc_mode_d = in_acc;
          // clear happens before the add, so an accumulate sees ACC_INIT
          if (in_clr) acc_d = ACC_INIT;
          add_b_d    = in_acc ? acc_d : in_b;
          state_d    = CALC;
        end
      end
      CALC: begin
        out_sum_d  = add_sum[31:0];
        out_cout_d = add_sum[32];
`ifdef ADD_STREAM_SAT_EN
        if (acc_mode_q && add_sum[32]) out_sum_d = 32'hFFFF_FFFF;
`endif
        if (acc_mode_q) acc_d = out_sum_d;
        state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == HOLD);
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_cin   = add_cin_q;
  assign out_sum   = out_sum_q;
  assign out_cout  = out_cout_q;
  assign acc_val   = acc_q;

endmodule

// File: tb/tb_add_stream_ctrl.sv
// Self-checking bench for add_stream_ctrl: directed spec cases plus randomized requests
// against an arithmetic reference model; honours ADD_STREAM_SAT_EN like the design.
module tb_add_stream_ctrl;

  localparam logic [31:0] INIT = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_a, in_b;
  logic        in_cin, in_acc, in_clr;
  logic [31:0] add_a, add_b;
  logic        add_cin;
  logic [32:0] add_sum;
  logic        out_valid, out_ready;
  logic [31:0] out_sum;
  logic        out_cout;
  logic [31:0] acc_val;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] acc_m;

  always #5 clk = ~clk;

  // external adder
  assign add_sum = {1'b0, add_a} + {1'b0, add_b} + {32'b0, add_cin};

  add_stream_ctrl #(.ACC_INIT(INIT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_acc(in_acc), .in_clr(in_clr),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .acc_val(acc_val)
  );

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    in_a   = $urandom;
    in_b   = $urandom;
    in_cin = 1'($urandom_range(0, 1));
    in_acc = 1'($urandom_range(0, 1));
    in_clr = 1'($urandom_range(0, 1));
  endtask

  // One full request: accept, CALC, HOLD for `stall` extra cycles, release.
  task automatic txn(input logic [31:0] a, input logic [31:0] b, input logic cin,
                     input logic acc, input logic clr, input int stall);
    logic [31:0] base, opb, acc_at_accept;
    logic [32:0] s;
    chk("idle_in_ready", in_ready, 1);
    base = clr ? INIT : acc_m;
    opb  = acc ? base : b;
    s    = {1'b0, a} + {1'b0, opb} + {32'b0, cin};
    acc_at_accept = clr ? INIT : acc_m;
    if (acc) begin
`ifdef ADD_STREAM_SAT_EN
      if (s[32]) s = {1'b1, 32'hFFFF_FFFF};
`endif
      acc_m = s[31:0];
    end else if (clr) begin
      acc_m = INIT;
    end
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin; in_acc = acc; in_clr = clr;
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble();
    chk("calc_add_a", add_a, a);
    chk("calc_add_b", add_b, opb);
    chk("calc_add_cin", add_cin, cin);
    chk("calc_in_ready", in_ready, 0);
    chk("calc_out_valid", out_valid, 0);
    chk("calc_acc_val", acc_val, acc_at_accept);
    @(posedge clk); #1;
    chk("hold_out_valid", out_valid, 1);
    chk("hold_out_sum", out_sum, s[31:0]);
    chk("hold_out_cout", out_cout, s[32]);
    chk("hold_acc_val", acc_val, acc_m);
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("stall_out_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_sum", {out_cout, out_sum}, s);
      chk("stall_add_a", add_a, a);
      chk("stall_acc_val", acc_val, acc_m);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release_out_valid", out_valid, 0);
    chk("release_in_ready", in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_cin = 1'b0; in_acc = 1'b0; in_clr = 1'b0;
    acc_m = INIT;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", {out_cout, out_sum}, 0);
    chk("rst_add", {add_cin, add_a}, 0);
    chk("rst_add_b", add_b, 0);
    chk("rst_acc_val", acc_val, INIT);
    @(negedge clk); rst = 1'b0;

    // pass-through and carry
    txn(32'h5, 32'h3, 1'b1, 1'b0, 1'b0, 0);
    chk("pass_sum9", out_sum, 32'h9);
    txn(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, 0);
    chk("carry_sum0", {out_cout, out_sum}, {1'b1, 32'h0});
    chk("carry_acc_unchanged", acc_val, INIT);

    // accumulate chain: clr+10, +20, +5+cin
    txn(32'd10, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1, 0);
    txn(32'd20, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 0);
    txn(32'd5,  32'h0, 1'b1, 1'b1, 1'b0, 0);
    chk("accum_acc36", acc_val, INIT + 32'd36);

    // backpressure
    txn(32'hA5A5_0000, 32'h0000_5A5A, 1'b0, 1'b0, 1'b0, 5);

    // wrap vs saturation
    txn(32'hFFFF_FFF0 - INIT, 32'h0, 1'b0, 1'b1, 1'b1, 0);
    txn(32'h20, 32'h0, 1'b0, 1'b1, 1'b0, 0);
`ifdef ADD_STREAM_SAT_EN
    chk("sat_sum", {out_cout, out_sum}, {1'b1, 32'hFFFF_FFFF});
    chk("sat_acc", acc_val, 32'hFFFF_FFFF);
`else
    chk("wrap_sum", {out_cout, out_sum}, {1'b1, 32'h10});
    chk("wrap_acc", acc_val, 32'h10);
`endif
    // pass-through never saturates
    txn(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1);

    // reset mid-CALC
    in_valid = 1'b1; in_a = 32'h7; in_b = 32'h0; in_cin = 1'b0; in_acc = 1'b1; in_clr = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rstcalc_out_valid", out_valid, 0);
    chk("rstcalc_in_ready", in_ready, 1);
    chk("rstcalc_acc_val", acc_val, INIT);
    chk("rstcalc_add_a", add_a, 0);
    @(posedge clk); #1;
    chk("rstcalc_out_valid2", out_valid, 0);
    @(negedge clk); rst = 1'b0;
    acc_m = INIT;
    txn(32'h1, 32'h2, 1'b0, 1'b1, 1'b0, 0);

    // randomized requests
    for (int n = 0; n < 40; n++) begin
      txn($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 3) == 0), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
